// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle used on both sides of a pipeline stage register.
// master drives valid/data and observes ready; slave does the opposite.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer (SKID=1) that makes upstream ready a pure register output.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W      = 64,
   parameter logic [DATA_W-1:0] FLUSH_VALUE = '0,
   parameter bit                SKID        = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   pipe_stage_reg_if.slave        in_bus,
   pipe_stage_reg_if.master       out_bus,
   output logic [1:0]             occupancy
);

   logic              m_valid, m_valid_nx;
   logic [DATA_W-1:0] m_data,  m_data_nx;
   logic              s_valid, s_valid_nx;
   logic [DATA_W-1:0] s_data,  s_data_nx;
   logic              ready;
   logic              accept;
   logic              emit;

   generate
      if (SKID) begin : g_skid_ready
         assign ready = !s_valid;
      end else begin : g_comb_ready
         assign ready = !m_valid | out_bus.ready;
      end
   endgenerate

   assign accept = in_bus.valid & ready;
   assign emit   = m_valid & out_bus.ready;

   always_comb begin
      m_valid_nx = m_valid;
      m_data_nx  = m_data;
      s_valid_nx = s_valid;
      s_data_nx  = s_data;
      if (flush) begin
         m_valid_nx = 1'b0;
         m_data_nx  = FLUSH_VALUE;
         s_valid_nx = 1'b0;
         s_data_nx  = FLUSH_VALUE;
      end else if (!SKID) begin
         if (accept) begin
            m_valid_nx = 1'b1;
            m_data_nx  = in_bus.data;
         end else if (emit) begin
            m_valid_nx = 1'b0;
         end
      end else if (!m_valid || emit) begin
         // M is free at this edge: refill from S first to keep acceptance order.
         if (s_valid) begin
            m_valid_nx = 1'b1;
            m_data_nx  = s_data;
            s_valid_nx = 1'b0;
         end else if (accept) begin
            m_valid_nx = 1'b1;
            m_data_nx  = in_bus.data;
         end else begin
            m_valid_nx = 1'b0;
         end
      end else if (accept) begin
         s_valid_nx = 1'b1;
         s_data_nx  = in_bus.data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_data  <= FLUSH_VALUE;
         s_valid <= 1'b0;
         s_data  <= FLUSH_VALUE;
      end else begin
         m_valid <= m_valid_nx;
         m_data  <= m_data_nx;
         s_valid <= s_valid_nx;
         s_data  <= s_data_nx;
      end
   end

   assign in_bus.ready  = ready;
   assign out_bus.valid = m_valid;
   assign out_bus.data  = m_data;
   assign occupancy     = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three stage instances (skid, no-skid, skid with nonzero flush value)
// checked every cycle against a queue-based reference, plus directed literal scenarios.
module tb_pipe_stage_reg;

   localparam int NI = 3;
   localparam bit          SK [NI] = '{1'b1, 1'b0, 1'b1};
   localparam logic [63:0] FV [NI] = '{64'h0, 64'h0, 64'h13};

   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   logic chk_en = 1'b0;

   logic        iv    [NI];
   logic [63:0] idata [NI];
   logic        ordy  [NI];
   logic        ov    [NI];
   logic [63:0] od    [NI];
   logic        rdy   [NI];
   logic [1:0]  occ   [NI];

   int tests = 0;
   int fails = 0;

   // reference: ordered list of held beats plus the value currently shown on out_data
   logic [63:0] mq     [NI][2];
   int          mcnt   [NI];
   logic [63:0] mshown [NI];

   pipe_stage_reg_if #(.DATA_W(64)) ib [NI] ();
   pipe_stage_reg_if #(.DATA_W(64)) ob [NI] ();

   for (genvar g = 0; g < NI; g++) begin : g_bind
      assign ib[g].valid = iv[g];
      assign ib[g].data  = idata[g];
      assign ob[g].ready = ordy[g];
      assign rdy[g]      = ib[g].ready;
      assign ov[g]       = ob[g].valid;
      assign od[g]       = ob[g].data;
   end

   pipe_stage_reg #(.DATA_W(64), .FLUSH_VALUE(64'h0), .SKID(1'b1)) dut0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_bus(ib[0]), .out_bus(ob[0]), .occupancy(occ[0]));
   pipe_stage_reg #(.DATA_W(64), .FLUSH_VALUE(64'h0), .SKID(1'b0)) dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_bus(ib[1]), .out_bus(ob[1]), .occupancy(occ[1]));
   pipe_stage_reg #(.DATA_W(64), .FLUSH_VALUE(64'h13), .SKID(1'b1)) dut2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_bus(ib[2]), .out_bus(ob[2]), .occupancy(occ[2]));

   initial forever begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit exp_rdy(int k);
      if (SK[k]) return mcnt[k] < 2;
      return (mcnt[k] == 0) || ordy[k];
   endfunction

   always @(posedge clk or posedge reset) begin
      bit a, e;
      for (int k = 0; k < NI; k++) begin
         if (reset || flush) begin
            mcnt[k]   = 0;
            mshown[k] = FV[k];
         end else begin
            a = iv[k] && exp_rdy(k);
            e = (mcnt[k] > 0) && ordy[k];
            if (e) begin
               mq[k][0] = mq[k][1];
               mcnt[k]--;
            end
            if (a) begin
               mq[k][mcnt[k]] = idata[k];
               mcnt[k]++;
            end
            if (mcnt[k] > 0) mshown[k] = mq[k][0];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("model.k%0d.out_valid", k), 64'(ov[k]), 64'(mcnt[k] != 0));
            chk($sformatf("model.k%0d.out_data", k), od[k], mshown[k]);
            chk($sformatf("model.k%0d.in_ready", k), 64'(rdy[k]), 64'(exp_rdy(k)));
            chk($sformatf("model.k%0d.occupancy", k), 64'(occ[k]), 64'(mcnt[k]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input int k, input logic v, input logic [63:0] d,
                      input logic [1:0] o, input logic r);
      chk($sformatf("%s.k%0d.out_valid", nm, k), 64'(ov[k]), 64'(v));
      chk($sformatf("%s.k%0d.out_data", nm, k), od[k], d);
      chk($sformatf("%s.k%0d.occupancy", nm, k), 64'(occ[k]), 64'(o));
      chk($sformatf("%s.k%0d.in_ready", nm, k), 64'(rdy[k]), 64'(r));
   endtask

   task automatic idle();
      for (int k = 0; k < NI; k++) begin
         iv[k] = 1'b0;
         idata[k] = '0;
         ordy[k] = 1'b1;
      end
   endtask

   initial begin
      idle();
      for (int k = 0; k < NI; k++) begin
         mcnt[k] = 0;
         mshown[k] = FV[k];
      end
      // reset with clock stopped
      #2 reset = 1'b1;
      #1;
      lit("rst", 0, 1'b0, 64'h0, 2'd0, 1'b1);
      lit("rst", 1, 1'b0, 64'h0, 2'd0, 1'b1);
      lit("rst", 2, 1'b0, 64'h13, 2'd0, 1'b1);
      chk_en = 1'b1;
      clk_run = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();

      // streaming through the skid instance
      for (int i = 1; i <= 8; i++) begin
         iv[0] = 1'b1;
         idata[0] = 64'(i);
         step();
         lit("stream", 0, 1'b1, 64'(i), 2'd1, 1'b1);
      end
      iv[0] = 1'b0;
      step();
      lit("stream_end", 0, 1'b0, 64'h8, 2'd0, 1'b1);

      // backpressure: A in M, B in S, C held upstream
      ordy[0] = 1'b0;
      iv[0] = 1'b1; idata[0] = 64'hA; step();
      idata[0] = 64'hB; step();
      lit("bp_full", 0, 1'b1, 64'hA, 2'd2, 1'b0);
      idata[0] = 64'hC; step();
      lit("bp_hold", 0, 1'b1, 64'hA, 2'd2, 1'b0);
      ordy[0] = 1'b1; step();
      lit("bp_b", 0, 1'b1, 64'hB, 2'd1, 1'b1);
      step();
      lit("bp_c", 0, 1'b1, 64'hC, 2'd1, 1'b1);
      iv[0] = 1'b0; step();
      lit("bp_drain", 0, 1'b0, 64'hC, 2'd0, 1'b1);

      // flush with M=A, S=B and C offered
      ordy[0] = 1'b0;
      iv[0] = 1'b1; idata[0] = 64'hA; step();
      idata[0] = 64'hB; step();
      idata[0] = 64'hC; flush = 1'b1; step();
      flush = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
      lit("flush", 0, 1'b0, 64'h0, 2'd0, 1'b1);
      step();
      lit("flush_after", 0, 1'b0, 64'h0, 2'd0, 1'b1);

      // no-skid stall then simultaneous emit and load
      ordy[1] = 1'b0; iv[1] = 1'b1; idata[1] = 64'h5; step();
      iv[1] = 1'b0; #1;
      lit("s0_stall", 1, 1'b1, 64'h5, 2'd1, 1'b0);
      ordy[1] = 1'b1; iv[1] = 1'b1; idata[1] = 64'h6; #1;
      chk("s0_ready_comb", 64'(rdy[1]), 64'h1);
      step();
      iv[1] = 1'b0;
      lit("s0_load", 1, 1'b1, 64'h6, 2'd1, 1'b1);
      step();
      lit("s0_drain", 1, 1'b0, 64'h6, 2'd0, 1'b1);

      // nonzero flush value
      ordy[2] = 1'b0; iv[2] = 1'b1; idata[2] = 64'h77; step();
      iv[2] = 1'b0;
      lit("fv_beat", 2, 1'b1, 64'h77, 2'd1, 1'b1);
      flush = 1'b1; step();
      flush = 1'b0; ordy[2] = 1'b1;
      lit("fv_flush", 2, 1'b0, 64'h13, 2'd0, 1'b1);

      // asynchronous reset mid-transfer, together with flush
      ordy[0] = 1'b0; iv[0] = 1'b1; idata[0] = 64'h21; step();
      idata[0] = 64'h22; step();
      iv[0] = 1'b0;
      lit("pre_areset", 0, 1'b1, 64'h21, 2'd2, 1'b0);
      #2 reset = 1'b1; flush = 1'b1;
      #1;
      lit("areset", 0, 1'b0, 64'h0, 2'd0, 1'b1);
      step();
      reset = 1'b0; flush = 1'b0; ordy[0] = 1'b1;
      step();

      // randomized traffic on all instances
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NI; k++) begin
            iv[k] = 1'($urandom_range(0, 1));
            idata[k] = {$urandom, $urandom};
            ordy[k] = ((c / 200) % 3 == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
         end
         flush = ($urandom_range(0, 39) == 0);
         step();
      end
      idle();
      flush = 1'b0;
      step();
      step();
      step();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed 32+32-bit IF/ID latch. Carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake, with stall (backpressure), flush, and an optional 2-entry skid buffer so that upstream ready is registered. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage widths.

## Interface
- DATA_W, 64: payload width in bits, ≥1 (IF/ID: {instr_address, instruction}).
- FLUSH_VALUE, {DATA_W{1'b0}}: value loaded into every data register on reset and flush.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  payload to downstream.
- occupancy  output  2  number of held beats (0..2; max 1 when SKID=0).

## Operation
- Storage: main entry M (m_valid, m_data) drives out_valid/out_data directly. Skid entry S (s_valid, s_data) exists only when SKID=1.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- SKID=0: in_ready = !m_valid | out_ready (combinational). On accept, M <= in_data, m_valid <= 1. On emit without accept, m_valid <= 0, m_data unchanged.
- SKID=1: in_ready = !s_valid (a pure register output, no path from out_ready).
  - M empty, accept: beat goes to M.
  - M full, emit, S empty, accept: beat goes to M.
  - M full, no emit, accept: beat goes to S.
  - M full, emit, S full: S moves to M and S empties. No accept is possible because in_ready=0.
  - M full, emit, S empty, no accept: M empties.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- Flush (priority over every other transfer): at the edge, m_valid <= 0, s_valid <= 0, and all data registers <= FLUSH_VALUE. A beat offered in the flush cycle is discarded even if in_ready=1. An emit in the flush cycle still counts as taken by downstream.
- Stall: holding out_ready=0 freezes M. With SKID=1, one further beat is absorbed into S, then in_ready drops.
- occupancy = m_valid + s_valid.
- Data registers update only when loading a beat, on flush, or on reset.

## Timing
- Reset (asynchronous assert, release synchronous to clk): m_valid=0, s_valid=0, data=FLUSH_VALUE. Outputs are then out_valid=0, out_data=FLUSH_VALUE, occupancy=0, in_ready=1 (both modes).
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N and can be emitted at edge N+1.
- Throughput: 1 beat/cycle sustained in both modes when out_ready=1.
- SKID=1: in_ready falls in the cycle after S fills. It rises in the cycle after S drains.
- Flush: out_valid=0 and in_ready=1 in the cycle after the flush edge. A new beat can be accepted at the next edge.
- Reset mid-transfer: all held beats are lost immediately, without waiting for clk.
- Simultaneous flush and reset: reset dominates. The end state is identical to flush.

## Test plan
- Reset: assert reset with clk stopped -> out_valid=0, out_data=0, occupancy=0, in_ready=1 with no clock edge.
- Streaming (SKID=1, DATA_W=64): send beats 0x1..0x8 back-to-back with out_ready=1 -> 0x1..0x8 emitted on consecutive cycles, one cycle latency, in_ready stays 1.
- Backpressure (SKID=1): out_ready=0 while sending 0xA, 0xB, 0xC -> 0xA in M, 0xB in S, occupancy=2, in_ready=0, 0xC held upstream. Release out_ready -> output order 0xA, 0xB, 0xC with no loss.
- Flush (SKID=1): with M=0xA and S=0xB, assert flush while in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=FLUSH_VALUE, occupancy=0. 0xC is never emitted.
- SKID=0 stall: hold M=0x5 with out_ready=0 -> in_ready=0. Raise out_ready and present 0x6 in the same cycle -> 0x5 emitted, 0x6 loaded at that edge, occupancy stays 1.
- FLUSH_VALUE=64'h13: reset, then flush after one beat -> out_data=0x13 both times.
